mem_copy_engine: RTL and testbench

Bus-master block copy engine that drives the single-port 64×32 data memory from the initiator side. On a start pulse it reads `len` words beginning at `src` and writes them to consecutive addresses beginning at `dst`, using the memory's combinational read and clocked write. It sits beside the CPU datapath and owns the memory address, write-enable and write-data lines while busy. The CPU must not touch the memory during that time.

---
 rtl/mem_copy_engine.sv | 117 +++++++++++
 tb/tb_mem_copy_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block copy engine driving the single-port 64x32 data memory as bus master.
// Optional running checksum of copied words: define MEM_COPY_CHECKSUM_EN.
module mem_copy_engine (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  src,
    input  logic [5:0]  dst,
    input  logic [6:0]  len,
    input  logic [31:0] mem_rdata,
    output logic [5:0]  mem_addr,
    output logic        mem_mw,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    state_t      state;
    logic [5:0]  src_q;
    logic [5:0]  dst_q;
    logic [6:0]  len_q;
    logic [6:0]  idx;
    logic [6:0]  idx_next;

    assign idx_next = idx + 7'd1;

    // NOTE: outputs are registered alongside the state, so the async reset clears
    // mem_mw immediately and sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx       <= '0;
            mem_addr  <= '0;
            mem_mw    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == 7'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (len > 7'd64) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            src_q    <= src;
                            dst_q    <= dst;
                            len_q    <= len;
                            idx      <= '0;
                            state    <= READ;
                            busy     <= 1'b1;
                            mem_addr <= src;
                            mem_mw   <= 1'b0;
                        end
                    end
                end
                READ: begin
                    // mem_wdata doubles as the word buffer
                    mem_wdata <= mem_rdata;
                    mem_addr  <= dst_q + idx[5:0];
                    mem_mw    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    idx <= idx_next;
                    if (idx_next == len_q) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        mem_addr  <= '0;
                        mem_mw    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        state    <= READ;
                        mem_addr <= src_q + idx_next[5:0];
                        mem_mw   <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state == IDLE && start && len <= 7'd64) begin
            sum_q <= '0;
        end else if (state == READ) begin
            sum_q <= sum_q + mem_rdata;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: directed copies against a behavioural 64x32 memory.
module tb_mem_copy_engine;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  len;
    logic [31:0] mem_rdata;
    logic [5:0]  mem_addr;
    logic        mem_mw;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    mem_copy_engine dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_mw    (mem_mw),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [64];
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_mw) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          e0;
        int          offset;
        int          busy_n;
        int          mw_n;
        logic [31:0] sum;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef MEM_COPY_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    // Monitor: counts busy/write cycles and pops an expectation on every done/err pulse.
    int   busy_n = 0;
    int   mw_n = 0;
    exp_t e;
    always @(negedge CLK) begin
        if (reset) begin
            busy_n = 0;
            mw_n   = 0;
        end else begin
            if (busy)   busy_n++;
            if (mem_mw) mw_n++;
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, done, err}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {30'b0, done, err}, e.is_err ? 32'h1 : 32'h2);
                    check("pulse_offset", cyc - e.e0, e.offset);
                    check("busy_cycles", busy_n, e.busy_n);
                    check("write_cycles", mw_n, e.mw_n);
                    check("checksum", checksum, e.sum);
                end
                busy_n = 0;
                mw_n   = 0;
            end
        end
    end

    task automatic preload();
        for (int k = 0; k < 64; k++) mem[k] <= k;
    endtask

    task automatic issue(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                         input bit expect_pulse, input bit is_err, input int off,
                         input int bn, input int mn, input logic [31:0] sum);
        exp_t x;
        @(negedge CLK);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        if (expect_pulse) begin
            x.is_err = is_err;
            x.e0     = cyc;
            x.offset = off;
            x.busy_n = bn;
            x.mw_n   = mn;
            x.sum    = sum;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge CLK);
        check("completion_timeout", exp_q.size(), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        preload();
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_mw", mem_mw, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_checksum", checksum, 0);
        @(negedge CLK);
        reset = 1'b0;

        // Basic copy, with a second start while busy that must be ignored
        issue(6'd4, 6'd40, 7'd3, 1, 0, 6, 6, 3, cs(32'd15));
        repeat (2) @(negedge CLK);
        issue(6'd0, 6'd0, 7'd2, 0, 0, 0, 0, 0, 32'h0);
        wait_idle();
        check("t1_m40", mem[40], 4);
        check("t1_m41", mem[41], 5);
        check("t1_m42", mem[42], 6);

        // Source wraps past address 63
        issue(6'd62, 6'd10, 7'd4, 1, 0, 8, 8, 4, cs(32'd126));
        wait_idle();
        check("t2_m10", mem[10], 62);
        check("t2_m11", mem[11], 63);
        check("t2_m12", mem[12], 0);
        check("t2_m13", mem[13], 1);

        // Zero length: immediate done, no memory traffic
        issue(6'd0, 6'd20, 7'd0, 1, 0, 0, 0, 0, cs(32'd0));
        wait_idle();
        check("t3_m20", mem[20], 20);

        // Oversized length: err pulse, checksum holds
        issue(6'd5, 6'd20, 7'd65, 1, 1, 0, 0, 0, cs(32'd0));
        wait_idle();
        check("t4_m20", mem[20], 20);
        check("t4_m21", mem[21], 21);

        // Forward overlap propagates word 0
        issue(6'd0, 6'd1, 7'd3, 1, 0, 6, 6, 3, cs(32'd0));
        wait_idle();
        check("t5_m1", mem[1], 0);
        check("t5_m2", mem[2], 0);
        check("t5_m3", mem[3], 0);
        check("t5_m4", mem[4], 4);

        // Reset during WRITE of word 2
        preload();
        @(negedge CLK);
        issue(6'd0, 6'd32, 7'd5, 0, 0, 0, 0, 0, 32'h0);
        repeat (5) @(posedge CLK);
        #2;
        check("t6_pre_mw", mem_mw, 1);
        check("t6_pre_addr", mem_addr, 34);
        reset = 1'b1;
        #1;
        check("t6_mw", mem_mw, 0);
        check("t6_busy", busy, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_wdata", mem_wdata, 0);
        check("t6_done", done, 0);
        check("t6_checksum", checksum, 0);
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        repeat (4) @(negedge CLK);
        check("t6_m32", mem[32], 0);
        check("t6_m33", mem[33], 1);
        check("t6_m34", mem[34], 34);
        check("t6_m35", mem[35], 35);
        check("t6_m36", mem[36], 36);

        // Normal operation after reset
        issue(6'd8, 6'd50, 7'd2, 1, 0, 4, 4, 2, cs(32'd17));
        wait_idle();
        check("t7_m50", mem[50], 8);
        check("t7_m51", mem[51], 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
